// File: rtl/fun_fpusqr_wbq.sv
// fun_fpusqr_wbq: write-back queue for the FP sqrt/div unit.
// Holds completed sqrt/div results and replays them in order onto the
// alternate FP register-file write port when the main pipe leaves it idle.
// The pause output gives the scheduler enough warning to stop issuing
// before the queue overflows. Results are never bypassed to the port.
module fun_fpusqr_wbq #(
    parameter int DEPTH        = 4,
    parameter int PAUSE_MARGIN = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         except,
    input  logic [3:0]   in_en,
    input  logic [9:0]   in_II,
    input  logic [12:0]  in_op,
    input  logic [8:0]   in_reg,
    input  logic         in_wen,
    input  logic [135:0] in_data,
    input  logic         wb_slot_free,
    output logic [3:0]   wb_en,
    output logic [9:0]   wb_II,
    output logic [12:0]  wb_op,
    output logic [8:0]   wb_reg,
    output logic         wb_wen,
    output logic [135:0] wb_data,
    output logic [3:0]   fxFRT_alten,
    output logic [3:0]   fxFRT_pause,
    output logic         ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] PAUSE_C = CW'(DEPTH - PAUSE_MARGIN);

    logic [3:0]   en_q   [DEPTH];
    logic [9:0]   ii_q   [DEPTH];
    logic [12:0]  op_q   [DEPTH];
    logic [8:0]   reg_q  [DEPTH];
    logic         wen_q  [DEPTH];
    logic [135:0] data_q [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic push_req;
    logic push;
    logic pop;
    logic full;
    logic drop;

    // Handshake decode: a flush kills both the incoming result and any pop.
    // When full, a push is only accepted if the head leaves the same cycle.
    always_comb begin
        full     = (count == FULL_C);
        push_req = (|in_en) & ~except;
        pop      = (count != '0) & wb_slot_free & ~except;
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= ovf | drop;
            if (except) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            en_q[wr_ptr]   <= in_en;
            ii_q[wr_ptr]   <= in_II;
            op_q[wr_ptr]   <= in_op;
            reg_q[wr_ptr]  <= in_reg;
            wen_q[wr_ptr]  <= in_wen;
            data_q[wr_ptr] <= in_data;
        end
    end

    // Head presentation: fields are zeroed unless the head retires this cycle.
    always_comb begin
        wb_en   = '0;
        wb_II   = '0;
        wb_op   = '0;
        wb_reg  = '0;
        wb_wen  = 1'b0;
        wb_data = '0;
        if (pop) begin
            wb_en   = en_q[rd_ptr];
            wb_II   = ii_q[rd_ptr];
            wb_op   = op_q[rd_ptr];
            wb_reg  = reg_q[rd_ptr];
            wb_wen  = wen_q[rd_ptr];
            wb_data = data_q[rd_ptr];
        end
    end

    // Scheduler feedback, replicated per lane, from registered occupancy only.
    always_comb begin
        fxFRT_alten = {4{count != '0}};
        fxFRT_pause = {4{count >= PAUSE_C}};
    end

endmodule

// File: tb/tb_fun_fpusqr_wbq.sv
// tb_fun_fpusqr_wbq: directed bench for the sqrt/div write-back queue.
module tb_fun_fpusqr_wbq;

    logic         clk = 1'b0;
    logic         rst;
    logic         except;
    logic [3:0]   in_en;
    logic [9:0]   in_II;
    logic [12:0]  in_op;
    logic [8:0]   in_reg;
    logic         in_wen;
    logic [135:0] in_data;
    logic         wb_slot_free;
    logic [3:0]   wb_en;
    logic [9:0]   wb_II;
    logic [12:0]  wb_op;
    logic [8:0]   wb_reg;
    logic         wb_wen;
    logic [135:0] wb_data;
    logic [3:0]   fxFRT_alten;
    logic [3:0]   fxFRT_pause;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    fun_fpusqr_wbq #(.DEPTH(4), .PAUSE_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .except(except),
        .in_en(in_en), .in_II(in_II), .in_op(in_op), .in_reg(in_reg),
        .in_wen(in_wen), .in_data(in_data), .wb_slot_free(wb_slot_free),
        .wb_en(wb_en), .wb_II(wb_II), .wb_op(wb_op), .wb_reg(wb_reg),
        .wb_wen(wb_wen), .wb_data(wb_data),
        .fxFRT_alten(fxFRT_alten), .fxFRT_pause(fxFRT_pause), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Full write-back word as it must appear when a result tagged ii retires.
    function automatic logic [172:0] exp_word(input logic [9:0] ii);
        logic [3:0]   en;
        logic [12:0]  op;
        logic [8:0]   rg;
        logic [135:0] dt;
        en = {ii[1:0], 2'b01};
        op = {3'b101, ii};
        rg = {ii[8:0]} ^ 9'h0AA;
        dt = {58'h0, ii, 58'h0, ~ii};
        return {en, ii, op, rg, ii[0], dt};
    endfunction

    function automatic logic [172:0] dut_word();
        return {wb_en, wb_II, wb_op, wb_reg, wb_wen, wb_data};
    endfunction

    task automatic drive_push(input logic [9:0] ii);
        in_en   = {ii[1:0], 2'b01};
        in_II   = ii;
        in_op   = {3'b101, ii};
        in_reg  = ii[8:0] ^ 9'h0AA;
        in_wen  = ii[0];
        in_data = {58'h0, ii, 58'h0, ~ii};
    endtask

    task automatic idle();
        in_en = 4'h0; in_II = '0; in_op = '0; in_reg = '0; in_wen = 1'b0; in_data = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; except = 1'b0; wb_slot_free = 1'b1;
        idle();
        #2;
        checks++; if (fxFRT_alten !== 4'h0) begin errors++; $display("FAIL reset_alten: got %h expected 0", fxFRT_alten); end
        checks++; if (fxFRT_pause !== 4'h0) begin errors++; $display("FAIL reset_pause: got %h expected 0", fxFRT_pause); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (dut_word() !== '0) begin errors++; $display("FAIL reset_wb: got %h expected 0", dut_word()); end
        @(negedge clk);
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        wb_slot_free = 1'b1;
        in_en = 4'h3; in_II = 10'h7; in_op = 13'h55; in_reg = 9'h1A; in_wen = 1'b1; in_data = 136'h5;
        #2;
        checks++; if (wb_en !== 4'h0) begin errors++; $display("FAIL single_nobypass: got %h expected 0", wb_en); end
        cyc(); idle(); #2;
        checks++; if (wb_en !== 4'h3) begin errors++; $display("FAIL single_en: got %h expected 3", wb_en); end
        checks++; if (wb_reg !== 9'h1A) begin errors++; $display("FAIL single_reg: got %h expected 1a", wb_reg); end
        checks++; if (wb_data !== 136'h5) begin errors++; $display("FAIL single_data: got %h expected 5", wb_data); end
        checks++; if (wb_wen !== 1'b1) begin errors++; $display("FAIL single_wen: got %b expected 1", wb_wen); end
        checks++; if ({wb_II, wb_op} !== {10'h7, 13'h55}) begin errors++; $display("FAIL single_ii_op: got %h/%h expected 7/55", wb_II, wb_op); end
        checks++; if (fxFRT_alten !== 4'hF) begin errors++; $display("FAIL single_alten: got %h expected f", fxFRT_alten); end
        cyc(); #2;
        checks++; if (wb_en !== 4'h0) begin errors++; $display("FAIL single_after_en: got %h expected 0", wb_en); end
        checks++; if (fxFRT_alten !== 4'h0) begin errors++; $display("FAIL single_after_alten: got %h expected 0", fxFRT_alten); end
    endtask

    task automatic test_pause_drain();
        wb_slot_free = 1'b0;
        cyc(); drive_push(10'd1); #2;
        checks++; if (fxFRT_pause !== 4'h0) begin errors++; $display("FAIL pd_pause0: got %h expected 0", fxFRT_pause); end
        cyc(); drive_push(10'd2); #2;
        checks++; if (fxFRT_pause !== 4'h0) begin errors++; $display("FAIL pd_pause1: got %h expected 0", fxFRT_pause); end
        checks++; if (fxFRT_alten !== 4'hF) begin errors++; $display("FAIL pd_alten1: got %h expected f", fxFRT_alten); end
        checks++; if (wb_en !== 4'h0) begin errors++; $display("FAIL pd_busy_en: got %h expected 0", wb_en); end
        cyc(); drive_push(10'd3); #2;
        checks++; if (fxFRT_pause !== 4'hF) begin errors++; $display("FAIL pd_pause2: got %h expected f", fxFRT_pause); end
        cyc(); idle(); wb_slot_free = 1'b1; #2;
        for (int k = 1; k <= 3; k++) begin
            checks++; if (dut_word() !== exp_word(10'(k))) begin errors++; $display("FAIL pd_drain%0d: got %h expected %h", k, dut_word(), exp_word(10'(k))); end
            cyc(); #2;
        end
        checks++; if ({fxFRT_alten, fxFRT_pause, wb_en} !== 12'h0) begin errors++; $display("FAIL pd_empty: got %h expected 0", {fxFRT_alten, fxFRT_pause, wb_en}); end
    endtask

    task automatic test_overflow();
        wb_slot_free = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(); drive_push(10'(11 + k));
        end
        cyc(); drive_push(10'd15); #2;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", ovf); end
        cyc(); idle(); #2;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        wb_slot_free = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (dut_word() !== exp_word(10'(11 + k))) begin errors++; $display("FAIL ovf_drain%0d: got %h expected %h", k, dut_word(), exp_word(10'(11 + k))); end
            cyc(); #2;
        end
        checks++; if ({fxFRT_alten, wb_en} !== 8'h0) begin errors++; $display("FAIL ovf_dropped: got %h expected 0", {fxFRT_alten, wb_en}); end
        cyc(); except = 1'b1;
        cyc(); except = 1'b0; #2;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky_except: got %b expected 1", ovf); end
        wb_slot_free = 1'b0;
        cyc(); drive_push(10'd60);
        cyc(); drive_push(10'd61);
        cyc(); idle(); #2;
        checks++; if (fxFRT_alten !== 4'hF) begin errors++; $display("FAIL rstmid_pre: got %h expected f", fxFRT_alten); end
        #1 rst = 1'b0;
        #1;
        checks++; if ({fxFRT_alten, fxFRT_pause, ovf} !== 9'h0) begin errors++; $display("FAIL rstmid_clear: got %h expected 0", {fxFRT_alten, fxFRT_pause, ovf}); end
        @(negedge clk); rst = 1'b1;
        cyc(); wb_slot_free = 1'b1; #2;
        checks++; if (wb_en !== 4'h0) begin errors++; $display("FAIL rstmid_lost: got %h expected 0", wb_en); end
    endtask

    task automatic test_full_push_pop();
        wb_slot_free = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(); drive_push(10'(21 + k));
        end
        cyc(); drive_push(10'd9); wb_slot_free = 1'b1; #2;
        checks++; if (dut_word() !== exp_word(10'd21)) begin errors++; $display("FAIL fpp_head: got %h expected %h", dut_word(), exp_word(10'd21)); end
        cyc(); idle(); #2;
        checks++; if (fxFRT_pause !== 4'hF) begin errors++; $display("FAIL fpp_still_full: got %h expected f", fxFRT_pause); end
        for (int k = 0; k < 4; k++) begin
            logic [9:0] e;
            e = (k == 3) ? 10'd9 : 10'(22 + k);
            checks++; if (dut_word() !== exp_word(e)) begin errors++; $display("FAIL fpp_drain%0d: got %h expected %h", k, dut_word(), exp_word(e)); end
            cyc(); #2;
        end
        checks++; if ({fxFRT_alten, wb_en, ovf} !== 9'h0) begin errors++; $display("FAIL fpp_end: got %h expected 0", {fxFRT_alten, wb_en, ovf}); end
    endtask

    task automatic test_flush();
        wb_slot_free = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(); drive_push(10'(31 + k));
        end
        cyc(); drive_push(10'd34); except = 1'b1; wb_slot_free = 1'b1; #2;
        checks++; if (wb_en !== 4'h0) begin errors++; $display("FAIL flush_nopop: got %h expected 0", wb_en); end
        checks++; if (fxFRT_alten !== 4'hF) begin errors++; $display("FAIL flush_pre_alten: got %h expected f", fxFRT_alten); end
        cyc(); idle(); except = 1'b0; #2;
        checks++; if ({fxFRT_alten, fxFRT_pause} !== 8'h0) begin errors++; $display("FAIL flush_cleared: got %h expected 0", {fxFRT_alten, fxFRT_pause}); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (wb_en !== 4'h0) begin errors++; $display("FAIL flush_noissue%0d: got %h expected 0", k, wb_en); end
            cyc(); #2;
        end
    endtask

    task automatic test_wrap();
        wb_slot_free = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(); drive_push(10'(40 + i)); #2;
            if (i == 0) begin
                checks++; if (wb_en !== 4'h0) begin errors++; $display("FAIL wrap_first: got %h expected 0", wb_en); end
            end else begin
                checks++; if (dut_word() !== exp_word(10'(39 + i))) begin errors++; $display("FAIL wrap%0d: got %h expected %h", i, dut_word(), exp_word(10'(39 + i))); end
            end
            checks++; if (fxFRT_pause !== 4'h0) begin errors++; $display("FAIL wrap_pause%0d: got %h expected 0", i, fxFRT_pause); end
        end
        cyc(); idle(); #2;
        checks++; if (dut_word() !== exp_word(10'd49)) begin errors++; $display("FAIL wrap_last: got %h expected %h", dut_word(), exp_word(10'd49)); end
        cyc(); #2;
        checks++; if (fxFRT_alten !== 4'h0) begin errors++; $display("FAIL wrap_empty: got %h expected 0", fxFRT_alten); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pause_drain();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
